// File: rtl/domain_seq_pkg.sv
// Shared types for the domain enable sequencer: FSM state encoding and width.
package domain_seq_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    IDLE      = 3'd0,
    FILTER    = 3'd1,
    RAMP_UP   = 3'd2,
    RUN       = 3'd3,
    RAMP_DOWN = 3'd4
  } seq_state_t;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous level into the clk domain.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic async_rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the sampled level one stage further each cycle.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchroniser flops, cleared to 0 so lock reads as absent out of reset.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) sync_q <= '0;
    else           sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/domain_enable_sequencer.sv
// Qualifies PLL lock, then raises per-domain enables one at a time in index
// order with a fixed stagger, and unwinds them in reverse order on lock loss
// or request withdrawal. seq_state exposes the FSM for debug.
module domain_enable_sequencer
  import domain_seq_pkg::*;
#(
  parameter int DOMAIN_COUNT       = 4,
  parameter int LOCK_FILTER_CYCLES = 64,
  parameter int STAGGER_CYCLES     = 16,
  parameter int SYNC_STAGES        = 2
) (
  input  logic                    clk,
  input  logic                    async_rst,
  input  logic                    clk_lock,
  input  logic                    sw_enable,
  input  logic                    clear_sticky,
  output logic [DOMAIN_COUNT-1:0] domain_enable,
  output logic                    all_up,
  output logic [SEQ_STATE_W-1:0]  seq_state,
  output logic                    lock_lost_sticky
);

  localparam int FILT_W = $clog2(LOCK_FILTER_CYCLES + 1);
  localparam int STG_W  = $clog2(STAGGER_CYCLES + 1);
  localparam int IDX_W  = $clog2(DOMAIN_COUNT + 1);

  localparam logic [FILT_W-1:0] FILT_LAST  = FILT_W'(LOCK_FILTER_CYCLES - 1);
  localparam logic [STG_W-1:0]  STG_RELOAD = STG_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DOMAIN_COUNT - 1);

  logic lock_s;

  seq_state_t              state_q,  state_d;
  logic [FILT_W-1:0]       filt_q,   filt_d;
  logic [STG_W-1:0]        stg_q,    stg_d;
  logic [IDX_W-1:0]        idx_q,    idx_d;
  logic [DOMAIN_COUNT-1:0] en_q,     en_d;
  logic                    all_up_q, all_up_d;
  logic                    sticky_q, sticky_d;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk       (clk),
    .async_rst (async_rst),
    .d         (clk_lock),
    .q         (lock_s)
  );

  // Next-state, counters and enable pattern. idx counts how many enables are
  // set; the enable vector is the thermometer decode of idx, registered.
  always_comb begin
    state_d  = state_q;
    filt_d   = filt_q;
    stg_d    = (stg_q == '0) ? '0 : stg_q - 1'b1;
    idx_d    = idx_q;
    sticky_d = sticky_q & ~clear_sticky;

    case (state_q)
      IDLE: begin
        if (sw_enable) begin
          state_d = FILTER;
          filt_d  = '0;
        end
      end
      FILTER: begin
        if (!sw_enable) begin
          state_d = IDLE;
          filt_d  = '0;
        end else if (!lock_s) begin
          filt_d = '0;
        end else if (filt_q == FILT_LAST) begin
          state_d = RAMP_UP;
          filt_d  = '0;
          stg_d   = '0;  // first enable goes out on the first RAMP_UP cycle
        end else begin
          filt_d = filt_q + 1'b1;
        end
      end
      RAMP_UP: begin
        if (!lock_s || !sw_enable) begin
          state_d = RAMP_DOWN;
          stg_d   = '0;  // highest set bit clears on the first RAMP_DOWN cycle
        end else if (stg_q == '0) begin
          idx_d = idx_q + 1'b1;
          stg_d = STG_RELOAD;
          if (idx_q == IDX_LAST) state_d = RUN;
        end
      end
      RUN: begin
        if (!lock_s || !sw_enable) begin
          state_d = RAMP_DOWN;
          stg_d   = '0;
        end
      end
      RAMP_DOWN: begin
        if (en_q == '0) begin
          state_d = IDLE;
        end else if (stg_q == '0) begin
          idx_d = idx_q - 1'b1;
          stg_d = STG_RELOAD;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q == RAMP_UP || state_q == RUN) && !lock_s) sticky_d = 1'b1;

    for (int k = 0; k < DOMAIN_COUNT; k++) begin
      en_d[k] = (k < int'(idx_d));
    end

    all_up_d = (state_q == RUN) && (state_d == RUN) && (&en_q);
  end

  // State and datapath registers, all asynchronously reset.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q  <= IDLE;
      filt_q   <= '0;
      stg_q    <= '0;
      idx_q    <= '0;
      en_q     <= '0;
      all_up_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      filt_q   <= filt_d;
      stg_q    <= stg_d;
      idx_q    <= idx_d;
      en_q     <= en_d;
      all_up_q <= all_up_d;
      sticky_q <= sticky_d;
    end
  end

  assign domain_enable    = en_q;
  assign all_up           = all_up_q;
  assign seq_state        = state_q;
  assign lock_lost_sticky = sticky_q;

endmodule

// File: tb/tb_domain_enable_sequencer.sv
// Directed bench for domain_enable_sequencer with default parameters.
// Cycle numbers count rising edges since the last reset release; inputs are
// driven and outputs sampled 1 time unit after the rising edge.
module tb_domain_enable_sequencer;

  logic       clk;
  logic       async_rst;
  logic       clk_lock;
  logic       sw_enable;
  logic       clear_sticky;
  logic [3:0] domain_enable;
  logic       all_up;
  logic [2:0] seq_state;
  logic       lock_lost_sticky;

  int n_checks;
  int n_pass;
  int cyc;

  domain_enable_sequencer dut (
    .clk              (clk),
    .async_rst        (async_rst),
    .clk_lock         (clk_lock),
    .sw_enable        (sw_enable),
    .clear_sticky     (clear_sticky),
    .domain_enable    (domain_enable),
    .all_up           (all_up),
    .seq_state        (seq_state),
    .lock_lost_sticky (lock_lost_sticky)
  );

  // Clock and reset-free clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp_v);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) begin
      step();
      cyc++;
    end
  endtask

  task automatic do_reset();
    async_rst = 1'b1;
    step();
    step();
    async_rst = 1'b0;
    cyc = 0;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] en, input logic [2:0] st,
                            input logic au, input logic sk);
    check({tag, ".en"},     32'(domain_enable),    32'(en));
    check({tag, ".state"},  32'(seq_state),        32'(st));
    check({tag, ".all_up"}, 32'(all_up),           32'(au));
    check({tag, ".sticky"}, 32'(lock_lost_sticky), 32'(sk));
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    cyc          = 0;
    async_rst    = 1'b1;
    clk_lock     = 1'b1;
    sw_enable    = 1'b1;
    clear_sticky = 1'b0;
    #2;
    check_outs("reset", 4'h0, 3'd0, 1'b0, 1'b0);
    step();
    async_rst = 1'b0;
    cyc = 0;

    // Power-up ramp: lock_s high after edge 2, 64 filter cycles, RAMP_UP at 66.
    run_to(1);   check_outs("pu_filter", 4'h0, 3'd1, 1'b0, 1'b0);
    run_to(65);  check("pu_still_filter", 32'(seq_state), 32'd1);
    run_to(66);  check_outs("pu_rampup_entry", 4'h0, 3'd2, 1'b0, 1'b0);
    run_to(67);  check("pu_bit0", 32'(domain_enable), 32'h1);
    run_to(82);  check("pu_before_bit1", 32'(domain_enable), 32'h1);
    run_to(83);  check("pu_bit1", 32'(domain_enable), 32'h3);
    run_to(99);  check("pu_bit2", 32'(domain_enable), 32'h7);
    run_to(115); check_outs("pu_bit3", 4'hf, 3'd3, 1'b0, 1'b0);
    run_to(116); check_outs("pu_all_up", 4'hf, 3'd3, 1'b1, 1'b0);

    // Withdraw request in RUN: RAMP_DOWN at 121, bits fall at 122/138/154/170.
    run_to(120); sw_enable = 1'b0;
    run_to(121); check_outs("sw_drop", 4'hf, 3'd4, 1'b0, 1'b0);
    run_to(122); check("sw_bit3_off", 32'(domain_enable), 32'h7);
    run_to(137); check("sw_hold", 32'(domain_enable), 32'h7);
    run_to(138); check("sw_bit2_off", 32'(domain_enable), 32'h3);
    run_to(154); check("sw_bit1_off", 32'(domain_enable), 32'h1);
    run_to(170); check_outs("sw_bit0_off", 4'h0, 3'd4, 1'b0, 1'b0);
    run_to(171); check_outs("sw_idle", 4'h0, 3'd0, 1'b0, 1'b0);
    run_to(175); check("sw_stay_idle", 32'(seq_state), 32'd0);

    // Lock glitch seen by lock_s while filt_cnt is 40: RAMP_UP moves 66 -> 107.
    sw_enable = 1'b1;
    clk_lock  = 1'b1;
    do_reset();
    run_to(40);  clk_lock = 1'b0;
    run_to(41);  clk_lock = 1'b1;
    run_to(67);  check_outs("gl_no_ramp", 4'h0, 3'd1, 1'b0, 1'b0);
    run_to(106); check("gl_still_filter", 32'(seq_state), 32'd1);
    run_to(107); check_outs("gl_rampup", 4'h0, 3'd2, 1'b0, 1'b0);
    run_to(108); check("gl_bit0", 32'(domain_enable), 32'h1);
    run_to(124); check("gl_bit1", 32'(domain_enable), 32'h3);

    // Lock loss during RAMP_UP after bit 1: sticky and RAMP_DOWN at 129.
    run_to(126); clk_lock = 1'b0;
    run_to(128); check_outs("ll_before", 4'h3, 3'd2, 1'b0, 1'b0);
    run_to(129); check_outs("ll_abort", 4'h3, 3'd4, 1'b0, 1'b1);
    run_to(130); check("ll_bit1_off", 32'(domain_enable), 32'h1);
    run_to(140); check("ll_no_bit2", 32'(domain_enable), 32'h1);
    run_to(145); check("ll_hold", 32'(domain_enable), 32'h1);
    run_to(146); check_outs("ll_bit0_off", 4'h0, 3'd4, 1'b0, 1'b1);
    run_to(147); check("ll_idle", 32'(seq_state), 32'd0);
    run_to(148); check("ll_refilter", 32'(seq_state), 32'd1);

    // Plain clear of the sticky flag.
    run_to(150); clear_sticky = 1'b1;
    run_to(151); clear_sticky = 1'b0; clk_lock = 1'b1;
    check("clr_alone", 32'(lock_lost_sticky), 32'd0);

    // Relock: lock_s high after 153, RAMP_UP at 217, RUN at 266, all_up at 267.
    run_to(217); check_outs("rl_rampup", 4'h0, 3'd2, 1'b0, 1'b0);
    run_to(266); check_outs("rl_run", 4'hf, 3'd3, 1'b0, 1'b0);
    run_to(267); check("rl_all_up", 32'(all_up), 32'd1);

    // Lock loss in RUN with clear_sticky in the same cycle: set wins.
    run_to(270); clk_lock = 1'b0;
    run_to(272); clear_sticky = 1'b1;
    run_to(273); clear_sticky = 1'b0;
    check_outs("setclr", 4'hf, 3'd4, 1'b0, 1'b1);
    run_to(274); clear_sticky = 1'b1;
    check("setclr_bit3_off", 32'(domain_enable), 32'h7);
    run_to(275); clear_sticky = 1'b0;
    check("setclr_later_clear", 32'(lock_lost_sticky), 32'd0);

    // Asynchronous reset mid-RAMP_DOWN, then a full restart.
    run_to(280);
    check("ar_mid_down", 32'(seq_state), 32'd4);
    clk_lock  = 1'b1;
    sw_enable = 1'b1;
    async_rst = 1'b1;
    #1;
    check_outs("ar_async", 4'h0, 3'd0, 1'b0, 1'b0);
    step();
    step();
    async_rst = 1'b0;
    cyc = 0;
    run_to(1);   check("ar_filter", 32'(seq_state), 32'd1);
    run_to(66);  check("ar_rampup", 32'(seq_state), 32'd2);
    run_to(67);  check("ar_bit0", 32'(domain_enable), 32'h1);
    run_to(115); check_outs("ar_run", 4'hf, 3'd3, 1'b0, 1'b0);
    run_to(116); check_outs("ar_all_up", 4'hf, 3'd3, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
